// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, fetch FSM state and reset PC shared by the CPU front end.
package cpu_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic {FETCH, HOLD} fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem req/ack bus plus decode valid/ready and branch controls.
interface instr_fetch_unit_if #(parameter int CNT_W = 32);
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc;
    logic             id_ready;
    logic             jump;
    logic             beq;
    logic             bne;
    logic             alu_zero;
    logic [CNT_W-1:0] issued_cnt;
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, issued_cnt,
        input  imem_ack, imem_rdata, id_ready, jump, beq, bne, alu_zero
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, issued_cnt,
        output imem_ack, imem_rdata, id_ready, jump, beq, bne, alu_zero
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// next_pc_calc: selects jump, taken-branch or sequential successor of if_pc.
module next_pc_calc (
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);
    logic [31:0] pc4;
    logic        taken;
    always_comb begin
        pc4     = if_pc + 32'd4;
        taken   = (beq && alu_zero) || (bne && !alu_zero);
        next_pc = jump  ? {pc4[31:28], if_instr[25:0], 2'b00} :
                  taken ? pc4 + {{14{if_instr[15]}}, if_instr[15:0], 2'b00} : pc4;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches over req/ack and hands words to decode over valid/ready.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input logic              clk,
    input logic              rst_n,
    instr_fetch_unit_if.master bus
);
    fetch_state_e     state_q, state_d;
    logic             started_q;
    logic [31:0]      pc_q, pc_d, instr_q, instr_d, ifpc_q, ifpc_d, next_pc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch, accept;

    next_pc_calc u_next_pc (
        .if_pc    (ifpc_q),
        .if_instr (instr_q),
        .jump     (bus.jump),
        .beq      (bus.beq),
        .bne      (bus.bne),
        .alu_zero (bus.alu_zero),
        .next_pc  (next_pc)
    );

    // started_q keeps the request low while reset is held and until the first edge after release
    assign fetch  = started_q && state_q == FETCH;
    assign accept = state_q == HOLD && bus.id_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        cnt_d   = cnt_q;
        if (fetch && bus.imem_ack) begin
            instr_d = bus.imem_rdata;
            ifpc_d  = pc_q;
            state_d = HOLD;
        end
        if (accept) begin
            pc_d    = next_pc;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            started_q <= 1'b0;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            ifpc_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ifpc_q    <= ifpc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.imem_req   = fetch;
    assign bus.imem_addr  = {pc_q[31:2], 2'b00};
    assign bus.if_valid   = state_q == HOLD;
    assign bus.if_instr   = instr_q;
    assign bus.if_pc      = ifpc_q;
    assign bus.issued_cnt = cnt_q;
endmodule
